// File: rtl/reg_ctrl_multi.sv
// Multi-channel floppy register controller: staged/active note registers, commit, mask,
// sticky error, per-channel watchdog, and a note-to-half-period lookup per channel.

module floppy_lookup (
    input  logic [6:0]  i_note,
    output logic [21:0] o_half_period
);
    // Half-period in 50 MHz clock cycles for the lowest octave (MIDI notes 0..11).
    logic [6:0]  w_octave;
    logic [6:0]  w_semi;
    logic [21:0] w_base;

    always_comb begin
        w_octave = i_note / 7'd12;
        w_semi   = i_note % 7'd12;
        w_base   = 22'd3057805;
        case (w_semi)
            7'd0:    w_base = 22'd3057805;
            7'd1:    w_base = 22'd2886184;
            7'd2:    w_base = 22'd2724195;
            7'd3:    w_base = 22'd2571296;
            7'd4:    w_base = 22'd2426983;
            7'd5:    w_base = 22'd2290767;
            7'd6:    w_base = 22'd2162196;
            7'd7:    w_base = 22'd2040840;
            7'd8:    w_base = 22'd1926298;
            7'd9:    w_base = 22'd1818183;
            7'd10:   w_base = 22'd1716135;
            7'd11:   w_base = 22'd1619818;
            default: w_base = 22'd3057805;
        endcase
        o_half_period = w_base >> w_octave;
    end
endmodule

module reg_ctrl_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           reg_addr,
    input  logic                 write,
    input  logic                 new_req,
    input  logic [7:0]           write_value,
    output logic [7:0]           read_value,
    output logic                 read_valid,
    output logic [7:0]           led,
    output logic [22*NUM_CH-1:0] f_sp,
    output logic [NUM_CH-1:0]    f_en
);
    localparam logic [5:0] ADDR_COMMIT = 6'h20;
    localparam logic [5:0] ADDR_MASK   = 6'h21;
    localparam logic [5:0] ADDR_STATUS = 6'h22;
    localparam logic [5:0] ADDR_TOFLAG = 6'h23;
    localparam logic [5:0] ADDR_ID     = 6'h3F;

    localparam bit          WD_EN   = (TIMEOUT_CYC != 0);
    localparam int unsigned CNT_W   = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(WD_EN ? TIMEOUT_CYC - 1 : 0);

    logic [7:0]       r_stg [NUM_CH];
    logic [7:0]       r_act [NUM_CH];
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_toflag;
    logic              r_pend;
    logic              r_err;
    logic [7:0]        r_read_value;
    logic              r_read_valid;

    logic [NUM_CH-1:0] w_stg_hit;
    logic              w_mapped;
    logic [7:0]        w_rdata;
    logic              w_wr;
    logic              w_rd;
    logic              w_commit;
    logic [NUM_CH-1:0] w_expire;
    logic [NUM_CH-1:0] w_toflag_clr;

    always_comb begin
        w_wr     = new_req & write;
        w_rd     = new_req & ~write;
        w_commit = w_wr && (reg_addr == ADDR_COMMIT);
        for (int i = 0; i < NUM_CH; i++) begin
            w_stg_hit[i] = (reg_addr == 6'(i));
            // A same-cycle commit reloads the channel, so it suppresses the expiry.
            w_expire[i]  = WD_EN && r_act[i][7] && (r_cnt[i] == TO_LAST) && !w_commit;
        end
        w_toflag_clr = (w_wr && reg_addr == ADDR_TOFLAG) ? write_value[NUM_CH-1:0] : '0;
    end

    always_comb begin
        w_mapped = 1'b1;
        w_rdata  = 8'h00;
        case (reg_addr)
            ADDR_COMMIT: w_rdata = {7'b0, r_pend};
            ADDR_MASK:   w_rdata = 8'(r_mask);
            ADDR_STATUS: w_rdata = {6'b0, r_err, r_pend};
            ADDR_TOFLAG: w_rdata = 8'(r_toflag);
            ADDR_ID:     w_rdata = {5'b0, 3'(NUM_CH - 1)};
            default: begin
                w_mapped = |w_stg_hit;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_stg_hit[i]) w_rdata = r_stg[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_stg[i] <= 8'h00;
                r_act[i] <= 8'h00;
                r_cnt[i] <= '0;
            end
            r_mask       <= '1;
            r_toflag     <= '0;
            r_pend       <= 1'b0;
            r_err        <= 1'b0;
            r_read_value <= 8'h00;
            r_read_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr && w_stg_hit[i]) r_stg[i] <= write_value;
                if (w_commit) begin
                    r_act[i] <= r_stg[i];
                    r_cnt[i] <= '0;
                end else if (w_expire[i]) begin
                    r_act[i][7] <= 1'b0;
                    r_cnt[i]    <= '0;
                end else if (WD_EN && r_act[i][7]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end

            if (w_commit) r_pend <= 1'b0;
            else if (w_wr && |w_stg_hit) r_pend <= 1'b1;

            if (w_wr && reg_addr == ADDR_MASK) r_mask <= write_value[NUM_CH-1:0];

            // Expiry set is OR-ed in last so it wins over a same-cycle clear.
            r_toflag <= (r_toflag & ~w_toflag_clr) | w_expire;

            if (new_req && !w_mapped) r_err <= 1'b1;
            else if (w_rd && reg_addr == ADDR_STATUS) r_err <= 1'b0;

            r_read_valid <= w_rd;
            if (w_rd) r_read_value <= w_rdata;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        floppy_lookup u_lookup (
            .i_note        (r_act[g][6:0]),
            .o_half_period (f_sp[22*g +: 22])
        );
        assign f_en[g] = r_act[g][7] & r_mask[g];
    end

    assign led        = 8'(f_en);
    assign read_value = r_read_value;
    assign read_valid = r_read_valid;
endmodule

// File: tb/tb_reg_ctrl_multi.sv
// Directed bench for reg_ctrl_multi with NUM_CH=4 and a 16-cycle watchdog.

module tb_reg_ctrl_multi;
    localparam int unsigned NCH = 4;

    logic              clk;
    logic              rst;
    logic [5:0]        reg_addr;
    logic              write;
    logic              new_req;
    logic [7:0]        write_value;
    logic [7:0]        read_value;
    logic              read_valid;
    logic [7:0]        led;
    logic [22*NCH-1:0] f_sp;
    logic [NCH-1:0]    f_en;

    int checks = 0;
    int errors = 0;
    int fall_n;

    reg_ctrl_multi #(.NUM_CH(NCH), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_addr    (reg_addr),
        .write       (write),
        .new_req     (new_req),
        .write_value (write_value),
        .read_value  (read_value),
        .read_valid  (read_valid),
        .led         (led),
        .f_sp        (f_sp),
        .f_en        (f_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All access tasks start and end on a falling edge.
    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        reg_addr = a; write = 1'b1; new_req = 1'b1; write_value = d;
        @(negedge clk);
        new_req = 1'b0; write = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] exp, input string tag);
        reg_addr = a; write = 1'b0; new_req = 1'b1;
        @(negedge clk);
        new_req = 1'b0;
        chk({tag, "_vld"}, 32'(read_valid), 32'd1);
        chk(tag, 32'(read_value), 32'(exp));
    endtask

    task automatic wait_fall0(input int start, input int limit);
        fall_n = start;
        while (f_en[0] && fall_n < limit) begin
            @(negedge clk);
            fall_n++;
        end
    endtask

    initial begin
        rst = 1'b1; reg_addr = '0; write = 1'b0; new_req = 1'b0; write_value = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_fen", 32'(f_en), 32'h0);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_sp0", 32'(f_sp[21:0]), 32'd3057805);
        chk("rst_sp3", 32'(f_sp[87:66]), 32'd3057805);
        chk("rst_rvld", 32'(read_valid), 32'd0);
        chk("rst_rval", 32'(read_value), 32'h00);
        do_read(6'h3F, 8'h03, "id");
        do_read(6'h21, 8'h0F, "mask_rst");

        // Stage two channels, then commit.
        do_write(6'h00, 8'hBC);
        do_write(6'h01, 8'h85);
        chk("stg_fen", 32'(f_en), 32'h0);
        do_read(6'h22, 8'h01, "status_pend");
        do_read(6'h00, 8'hBC, "stg0");
        do_write(6'h20, 8'hFF);
        chk("cmt_fen", 32'(f_en), 32'h3);
        chk("cmt_led", 32'(led), 32'h03);
        chk("cmt_sp0", 32'(f_sp[21:0]), 32'd95556);
        chk("cmt_sp1", 32'(f_sp[43:22]), 32'd2290767);
        do_read(6'h20, 8'h00, "pend_clr");

        // Mask.
        do_write(6'h21, 8'h02);
        chk("mask_fen", 32'(f_en), 32'h2);
        do_read(6'h21, 8'h02, "mask_rd");
        @(negedge clk);
        chk("rvld_pulse", 32'(read_valid), 32'd0);
        chk("rval_hold", 32'(read_value), 32'h02);

        // Watchdog expiry on channel 0 only.
        do_write(6'h21, 8'h0F);
        do_write(6'h00, 8'h80);
        do_write(6'h01, 8'h05);
        do_write(6'h20, 8'h00);
        chk("wd_fen_start", 32'(f_en), 32'h1);
        wait_fall0(0, 40);
        chk("wd_fall_cycles", 32'(fall_n), 32'd16);
        chk("wd_fen_end", 32'(f_en), 32'h0);
        do_read(6'h23, 8'h01, "toflag_set");
        do_write(6'h23, 8'h01);
        do_read(6'h23, 8'h00, "toflag_w1c");

        // Commit exactly on the expiry cycle keeps the channel alive.
        do_write(6'h20, 8'h00);
        repeat (15) @(negedge clk);
        chk("wd2_pre", 32'(f_en[0]), 32'd1);
        do_write(6'h20, 8'h00);
        chk("wd2_alive", 32'(f_en[0]), 32'd1);
        do_read(6'h23, 8'h00, "wd2_noflag");
        wait_fall0(1, 40);
        chk("wd2_fall_cycles", 32'(fall_n), 32'd16);
        do_read(6'h23, 8'h01, "wd2_flag");
        do_write(6'h23, 8'h0F);

        // Error handling.
        do_read(6'h10, 8'h00, "unmapped_rd");
        do_read(6'h22, 8'h02, "status_err");
        do_read(6'h22, 8'h00, "status_clr");
        do_write(6'h05, 8'hFF);
        do_read(6'h22, 8'h02, "err_wr_unmapped");
        do_write(6'h3F, 8'h11);
        chk("ro_wr_hold", 32'(read_value), 32'h02);
        chk("ro_wr_vld", 32'(read_valid), 32'd0);
        do_read(6'h22, 8'h00, "ro_wr_noerr");

        // Reset during an active count, with a concurrent request that must be ignored.
        do_write(6'h21, 8'h0E);
        do_write(6'h00, 8'h80);
        do_write(6'h20, 8'h00);
        repeat (5) @(negedge clk);
        do_read(6'h00, 8'h80, "pre_rst_stg");
        rst = 1'b1; reg_addr = 6'h20; write = 1'b1; new_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; new_req = 1'b0; write = 1'b0;
        chk("rst2_fen", 32'(f_en), 32'h0);
        chk("rst2_led", 32'(led), 32'h00);
        chk("rst2_sp0", 32'(f_sp[21:0]), 32'd3057805);
        chk("rst2_rvld", 32'(read_valid), 32'd0);
        chk("rst2_rval", 32'(read_value), 32'h00);
        repeat (30) @(negedge clk);
        do_read(6'h23, 8'h00, "rst2_noflag");
        do_read(6'h21, 8'h0F, "rst2_mask");
        do_read(6'h00, 8'h00, "rst2_stg");
        do_read(6'h20, 8'h00, "rst2_pend");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
